// File: rtl/inv_ip_arbiter.sv
// Round-robin front end sharing one combinational INV_IP among N_REQ requesters.
// Latency: a grant in cycle T gives out_valid in cycle T+1+CALC_CYC; registered operands reach the IP from T+1.
// Backpressure: a result is held in DONE until out_ready, and no new grant is issued until the handshake completes.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   req_valid / req_ready       per-requester handshake; req_ready is a one-hot grant, only ever issued in IDLE
//   req_in_1 / req_in_2         packed operands; requester i at [i*IP_WIDTH +: IP_WIDTH]
//   ip_in_1 / ip_in_2           registered operands driven to the external INV_IP
//   ip_out_inv                  combinational result from the INV_IP
//   out_valid / out_ready       result handshake; out_inv, out_id and out_err travel with out_valid
module inv_ip_arbiter #(
  parameter int IP_WIDTH = 6,
  parameter int N_REQ    = 4,
  parameter int CALC_CYC = 1,
  localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*IP_WIDTH-1:0] req_in_1,
  input  logic [N_REQ*IP_WIDTH-1:0] req_in_2,
  output logic [IP_WIDTH-1:0]       ip_in_1,
  output logic [IP_WIDTH-1:0]       ip_in_2,
  input  logic [IP_WIDTH-1:0]       ip_out_inv,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IP_WIDTH-1:0]       out_inv,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_err
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(CALC_CYC - 1);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     ptr;
  logic [3:0]          cnt;
  logic                bad_pair;

  // Arbitration results
  logic                found;
  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     win_id;
  logic [IP_WIDTH-1:0] sel_1, sel_2;
  logic                grant_fire;

  // Search upward from ptr, wrapping at N_REQ-1; first requester found wins.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    grant  = '0;
    win_id = '0;
    sel_1  = '0;
    sel_2  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win_id     = ID_W'(idx);
        sel_1      = req_in_1[idx*IP_WIDTH +: IP_WIDTH];
        sel_2      = req_in_2[idx*IP_WIDTH +: IP_WIDTH];
      end
    end
  end

  assign grant_fire = (state == S_IDLE) && found;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found)     state_nxt = S_CALC;
      S_CALC:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Output logic: the grant is only visible in IDLE and is suppressed while reset is held.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && !rst) req_ready = grant;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      cnt       <= '0;
      bad_pair  <= 1'b0;
      ip_in_1   <= '0;
      ip_in_2   <= '0;
      out_id    <= '0;
      out_inv   <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_fire) begin
            ip_in_1  <= sel_1;
            ip_in_2  <= sel_2;
            out_id   <= win_id;
            ptr      <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
            cnt      <= CNT_LOAD;
            // Zero operands or equal operands have no defined inverse.
            bad_pair <= (sel_1 == '0) || (sel_2 == '0) || (sel_1 == sel_2);
          end
        end
        S_CALC: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            out_inv   <= bad_pair ? '0 : ip_out_inv;
            out_err   <= bad_pair;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_ip_arbiter.sv
// Directed bench for inv_ip_arbiter: one instance at CALC_CYC=1 and one at CALC_CYC=4 on shared inputs.
// Each instance sees a behavioural INV_IP: inverse of the smaller operand modulo the larger.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_inv_ip_arbiter;

  localparam int W = 6;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_in_1 = '0;
  logic [N*W-1:0] req_in_2 = '0;
  logic           out_ready = 1'b1;

  logic [N-1:0]   req_ready,  req_ready4;
  logic [W-1:0]   ip_in_1,    ip_in_2,    ip_out_inv;
  logic [W-1:0]   ip_in_1_4,  ip_in_2_4,  ip_out_inv4;
  logic           out_valid,  out_valid4, out_err, out_err4;
  logic [W-1:0]   out_inv,    out_inv4;
  logic [1:0]     out_id,     out_id4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inv_ip_arbiter #(.IP_WIDTH(W), .N_REQ(N), .CALC_CYC(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_in_1(req_in_1), .req_in_2(req_in_2),
    .ip_in_1(ip_in_1), .ip_in_2(ip_in_2), .ip_out_inv(ip_out_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv),
    .out_id(out_id), .out_err(out_err)
  );

  inv_ip_arbiter #(.IP_WIDTH(W), .N_REQ(N), .CALC_CYC(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
    .req_in_1(req_in_1), .req_in_2(req_in_2),
    .ip_in_1(ip_in_1_4), .ip_in_2(ip_in_2_4), .ip_out_inv(ip_out_inv4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_inv(out_inv4),
    .out_id(out_id4), .out_err(out_err4)
  );

  // Behavioural INV_IP: larger operand is the modulus; 0 when no inverse exists.
  function automatic logic [W-1:0] inv_model(input logic [W-1:0] a, input logic [W-1:0] b);
    int m, x;
    logic [W-1:0] r;
    m = (a > b) ? int'(a) : int'(b);
    x = (a > b) ? int'(b) : int'(a);
    r = '0;
    if (x != 0 && a != b)
      for (int i = 1; i < m; i++)
        if (((x * i) % m) == 1 && r == '0) r = W'(i);
    return r;
  endfunction

  always_comb ip_out_inv  = inv_model(ip_in_1, ip_in_2);
  always_comb ip_out_inv4 = inv_model(ip_in_1_4, ip_in_2_4);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    req_in_1[r*W +: W] = a;
    req_in_2[r*W +: W] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One job on requester r at CALC_CYC=1; starts and ends at a falling edge with the block in IDLE.
  task automatic run_job(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_inv, input logic exp_err);
    req_valid = '0;
    req_valid[r] = 1'b1;
    set_op(r, a, b);
    out_ready = 1'b1;
    #1 check("job_grant", req_ready, 32'(1 << r));
    @(negedge clk);
    req_valid = '0;
    #1;
    check("job_ip_in_1", ip_in_1, a);
    check("job_ip_in_2", ip_in_2, b);
    check("job_calc_no_valid", out_valid, 0);
    @(negedge clk);
    #1;
    check("job_out_valid", out_valid, 1);
    check("job_out_inv", out_inv, exp_inv);
    check("job_out_id", out_id, r);
    check("job_out_err", out_err, exp_err);
    @(negedge clk);
    #1;
    check("job_valid_cleared", out_valid, 0);
    check("job_err_cleared", out_err, 0);
  endtask

  // All requesters valid continuously; grants must rotate with the given period.
  task automatic fairness(input int per, input bit use4);
    logic [N-1:0] rdy;
    logic         vld;
    logic [1:0]   id;
    for (int r = 0; r < N; r++) set_op(r, 6'd7, 6'd3);
    out_ready = 1'b1;
    do_reset();
    req_valid = '1;
    for (int c = 0; c < 6 * per; c++) begin
      #1;
      rdy = use4 ? req_ready4 : req_ready;
      vld = use4 ? out_valid4 : out_valid;
      id  = use4 ? out_id4    : out_id;
      check(use4 ? "fair4_grant" : "fair1_grant", rdy,
            (c % per == 0) ? 32'(1 << ((c / per) % N)) : 32'd0);
      check(use4 ? "fair4_valid" : "fair1_valid", vld, (c % per == per - 1) ? 1 : 0);
      if (c % per == per - 1)
        check(use4 ? "fair4_id" : "fair1_id", id, (c / per) % N);
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs
    rst       = 1'b1;
    req_valid = N'($urandom);
    req_in_1  = ($urandom);
    req_in_2  = ($urandom);
    out_ready = 1'($urandom);
    @(negedge clk);
    req_valid = 4'b1111;
    @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_inv", out_inv, 0);
    check("rst_out_id", out_id, 0);
    check("rst_out_err", out_err, 0);
    check("rst_ip_in_1", ip_in_1, 0);
    check("rst_ip_in_2", ip_in_2, 0);
    check("rst_req_ready4", req_ready4, 0);
    check("rst_out_valid4", out_valid4, 0);
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    // Single job: requester 2, (7,3) -> 5
    run_job(2, 6'd7, 6'd3, 6'd5, 1'b0);

    // Reset asserted mid-CALC discards the job
    req_valid = 4'b0010;
    set_op(1, 6'd7, 6'd3);
    #1 check("midrst_grant", req_ready, 32'b0010);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    check("midrst_ip_in_1", ip_in_1, 0);
    check("midrst_ip_in_2", ip_in_2, 0);
    check("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check("midrst_no_valid", out_valid, 0);
    end

    // Fairness at CALC_CYC=1 and CALC_CYC=4
    fairness(3, 1'b0);
    fairness(6, 1'b1);

    // Backpressure: requester 1 (11,5) -> 9 held while out_ready is low
    do_reset();
    out_ready = 1'b0;
    set_op(0, 6'd7, 6'd3);
    set_op(1, 6'd11, 6'd5);
    set_op(2, 6'd7, 6'd3);
    req_valid = 4'b0010;
    #1 check("bp_grant", req_ready, 32'b0010);
    @(negedge clk);
    req_valid = 4'b0101;
    #1 check("bp_calc_ready", req_ready, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_inv", out_inv, 9);
      check("bp_hold_id", out_id, 1);
      check("bp_hold_ready", req_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("bp_release_valid", out_valid, 1);
    @(negedge clk);
    #1 check("bp_next_grant", req_ready, 32'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    check("bp_next_id", out_id, 2);
    check("bp_next_inv", out_inv, 5);
    @(negedge clk);

    // Invalid operand pairs, then a valid one
    run_job(0, 6'd5, 6'd5, 6'd0, 1'b1);
    run_job(3, 6'd0, 6'd7, 6'd0, 1'b1);
    run_job(1, 6'd13, 6'd0, 6'd0, 1'b1);
    run_job(2, 6'd13, 6'd2, 6'd7, 1'b0);

    // Request withdrawal while DONE for requester 0
    do_reset();
    out_ready = 1'b0;
    for (int r = 0; r < N; r++) set_op(r, 6'd7, 6'd3);
    req_valid = 4'b1011;
    #1 check("wd_grant0", req_ready, 32'b0001);
    @(negedge clk);
    req_valid = 4'b1010;
    #1 check("wd_calc_ready", req_ready, 0);
    @(negedge clk);
    #1;
    check("wd_done_valid", out_valid, 1);
    check("wd_done_id", out_id, 0);
    check("wd_done_ready", req_ready, 0);
    req_valid = 4'b1000;
    out_ready = 1'b1;
    @(negedge clk);
    #1 check("wd_grant3", req_ready, 32'b1000);
    @(negedge clk);
    req_valid = 4'b0011;
    #1 check("wd_calc3_ready", req_ready, 0);
    @(negedge clk);
    #1 check("wd_done3_id", out_id, 3);
    @(negedge clk);
    #1 check("wd_wrap_grant", req_ready, 32'b0001);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
